// File: rtl/risc_controller_if.sv
// Control bus between the VeriRISC sequencer and its datapath.
// The sequencer is the master: it drives phase and every control strobe,
// and receives the stall enable, the resume pulse, the IR opcode and the
// accumulator-zero flag.
interface risc_controller_if #(
  parameter int OPCODE_WIDTH = 3
);
  logic                    enable;
  logic                    go;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    zero;
  logic [2:0]              phase;
  logic                    sel;
  logic                    rd;
  logic                    ld_ir;
  logic                    inc_pc;
  logic                    ld_pc;
  logic                    ld_ac;
  logic                    wr;
  logic                    data_e;
  logic                    halt;

  modport master (
    input  enable, go, opcode, zero,
    output phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt
  );

  modport slave (
    output enable, go, opcode, zero,
    input  phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt
  );
endinterface

// File: rtl/risc_controller.sv
// VeriRISC instruction sequencer: 8-phase fetch/execute counter plus a
// run/halt state. Control strobes are a combinational decode of the
// registered phase/run state together with opcode and zero, so they change
// in the same cycle as phase.
module risc_controller #(
  parameter int OPCODE_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  risc_controller_if.master    bus
);

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_SKZ = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_STO = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(7);

  localparam logic [2:0] PH_OP_ADDR  = 3'd4;
  localparam logic [2:0] PH_OP_FETCH = 3'd5;

  typedef enum logic {RUN, HALT} run_t;

  run_t       run_state;
  logic [2:0] phase_q;
  logic       is_hlt;
  logic       aluop;

  assign is_hlt = (bus.opcode == OP_HLT);
  assign aluop  = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                  (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);

  assign bus.phase = phase_q;

  // Phase sequencing and run/halt transitions; a HLT parks phase at OP_ADDR
  // and go resumes just after it so the HLT's remaining phases are idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= 3'd0;
      run_state <= RUN;
    end else begin
      case (run_state)
        RUN: begin
          if (bus.enable) begin
            if (phase_q == PH_OP_ADDR && is_hlt) begin
              run_state <= HALT;
            end else begin
              phase_q <= phase_q + 3'd1;
            end
          end
        end
        HALT: begin
          if (bus.go) begin
            run_state <= RUN;
            phase_q   <= PH_OP_FETCH;
          end
        end
        default: begin
          run_state <= RUN;
          phase_q   <= 3'd0;
        end
      endcase
    end
  end

  // Strobe decode; during a stall the side-effect strobes are masked while
  // the bus-level strobes (sel, rd, data_e) stay put to keep the bus stable.
  always_comb begin
    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.inc_pc = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.wr     = 1'b0;
    bus.data_e = 1'b0;
    bus.halt   = 1'b0;
    if (run_state == HALT) begin
      bus.halt = 1'b1;
    end else begin
      case (phase_q)
        3'd0: bus.sel = 1'b1;
        3'd1: begin
          bus.sel = 1'b1;
          bus.rd  = 1'b1;
        end
        3'd2, 3'd3: begin
          bus.sel   = 1'b1;
          bus.rd    = 1'b1;
          bus.ld_ir = 1'b1;
        end
        3'd4: begin
          bus.inc_pc = 1'b1;
          bus.halt   = is_hlt;
        end
        3'd5: bus.rd = aluop;
        3'd6: begin
          bus.rd     = aluop;
          bus.inc_pc = (bus.opcode == OP_SKZ) && bus.zero;
          bus.ld_pc  = (bus.opcode == OP_JMP);
          bus.data_e = (bus.opcode == OP_STO);
        end
        default: begin
          bus.rd     = aluop;
          bus.ld_ac  = aluop;
          bus.ld_pc  = (bus.opcode == OP_JMP);
          bus.wr     = (bus.opcode == OP_STO);
          bus.data_e = (bus.opcode == OP_STO);
        end
      endcase
      if (!bus.enable) begin
        bus.ld_ir  = 1'b0;
        bus.inc_pc = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.ld_ac  = 1'b0;
        bus.wr     = 1'b0;
      end
    end
  end

endmodule
